regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Arbitrates the single write port of the 16×16 register file between the pipeline writeback stage and the multi-cycle load-return path. Deferred load results wait in a small in-order buffer. A per-register scoreboard tracks registers with outstanding loads and raises `hazard` so decode stalls readers and writers of those registers. The block sits between the WB stage / memory return channel and the register file's `DstReg`/`WriteReg`/`writedata`/`LLB`/`LHB` inputs.

## Interface
- `BUF_DEPTH`, 2: load-return buffer entries (power of 2, ≥2)
- `DATA_W`, 16: register data width
- `REG_AW`, 4: register index width (16 registers)

Ports:
- `clk` in 1: sole clock, all state updates on posedge
- `rst_n` in 1: reset, asynchronous, active-low
- `wb_valid` in 1: pipeline writeback request; always accepted, highest priority
- `wb_reg` in `REG_AW`: writeback destination
- `wb_data` in `DATA_W`: writeback data
- `wb_llb`, `wb_lhb` in 1: byte-load qualifiers, passed to the register file
- `ld_valid` in 1: load-return data valid
- `ld_ready` out 1: buffer can accept (= count < `BUF_DEPTH`)
- `ld_reg` in `REG_AW`: load destination
- `ld_data` in `DATA_W`: load data
- `iss_valid` in 1: load issued to memory this cycle
- `iss_reg` in `REG_AW`: destination of the issued load
- `chk_reg1`, `chk_reg2`, `chk_dst` in `REG_AW`: decode-stage source/destination indices
- `hazard` out 1: some `chk_*` register is pending
- `rf_WriteReg` out 1, `rf_DstReg` out `REG_AW`, `rf_writedata` out `DATA_W`, `rf_LLB` out 1, `rf_LHB` out 1: register-file write port
- `buf_count` out clog2(`BUF_DEPTH`)+1: occupied buffer entries

## Operation
- Port select is combinational, with priority WB > buffer head > direct load bypass:
  - **WB:** `wb_valid` drives the port with `wb_*`.
  - **Buffer head:** else, if `buf_count` > 0, the head drives the port and is popped at the edge.
  - **Direct bypass:** else, if `ld_valid && ld_ready`, the load drives the port directly and is not buffered.
- An accepted load that does not own the port is pushed at the tail. Push and pop may happen in the same cycle; the count is then unchanged.
- Load writes always drive `rf_LLB = rf_LHB = 0`.
- Register 0 is hardwired:
  - Any selected write to reg 0 gives `rf_WriteReg = 0`, but the buffer pop and load acceptance still occur.
  - `iss_reg == 0` never sets a pending bit.
- Scoreboard `pend[15:0]`:
  - `iss_valid` sets `pend[iss_reg]`.
  - A load write reaching the port clears `pend[ld/head reg]`.
  - Set and clear of the same register in one cycle: set wins.
- `hazard = pend[chk_reg1] | pend[chk_reg2] | pend[chk_dst]`, combinational.
- States: EMPTY (count 0), PARTIAL, FULL (count = `BUF_DEPTH`, `ld_ready = 0`). Transitions follow push/pop.
- Occupancy arithmetic and pointer wrap:
  - Pointers wrap modulo `BUF_DEPTH`.
  - Count is `REG_AW`-independent.
  - Overflow is impossible because `ld_ready` gates pushes.
- `ld_valid` while FULL: no accept; the requester holds data stable.

## Timing
- Reset values: buffer empty, pointers 0, `pend = 0`, `buf_count = 0`, `ld_ready = 1`, `hazard = 0`.
- With no inputs asserted during reset: `rf_WriteReg = 0`, `rf_DstReg = 0`, `rf_writedata = 0`, `rf_LLB = 0`, `rf_LHB = 0`.
- Write port outputs are combinational from inputs and buffer state. The register file writes at the same posedge.
- Latency:
  - WB write: 0 cycles.
  - Bypassed load: 0 cycles.
  - Buffered load: written in the first cycle with no `wb_valid` and with all older entries drained.
- `pend` clear and register write land on the same edge, so decode sees `hazard = 0` and correct data in the following cycle.
- `ld_ready` depends on registered count only, never on `ld_valid` or `wb_valid`.
- `rst_n` low mid-operation: buffered loads and pending bits are discarded immediately. Upstream must also be reset.

## Structure
- Shared CPU package: `DATA_W`, `REG_AW`, and the `REG_ZERO = 0` constant.
- One sub-module: `wb_ld_fifo`, a parameterised synchronous FIFO with push/pop, count, full/empty. Its head and tail pointers are asynchronously reset.
- Scoreboard and port mux live in the top module.

## Test plan
- **Reset/idle:** hold `rst_n = 0`, then release → all outputs at reset values; `ld_ready = 1`.
- **Bypass:** `ld_valid`, `ld_reg = 3`, `ld_data = 16'h1234`, `wb_valid = 0` → same cycle `rf_WriteReg = 1`, `rf_DstReg = 3`, `rf_writedata = 16'h1234`; `buf_count` stays 0.
- **Contention:** `wb_valid` (reg 2, `16'hC130`) for 3 cycles while loads to reg 4 (`16'h00A5`) and reg 5 (`16'h2570`) arrive.
  - WB writes all 3 cycles.
  - `buf_count` reaches 2, `ld_ready = 0`.
  - After WB drops, reg 4 then reg 5 are written in consecutive cycles.
- **Scoreboard:**
  - `iss_valid`, `iss_reg = 7`; `chk_reg1 = 7` → `hazard = 1` until the cycle after the reg-7 load write, then 0.
  - Same-cycle issue and retire of reg 7 keeps `hazard = 1`.
- **Register 0:** load to reg 0 plus `iss_reg = 0` → `rf_WriteReg = 0`, load accepted, `hazard` never 1 for `chk_reg1 = 0`.
- **Reset mid-operation:** with `buf_count = 2` and `pend[5] = 1`, pulse `rst_n` low → `buf_count = 0`, `hazard = 0`, no further writes from discarded entries.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU constants and the load-return buffer occupancy states.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_PARTIAL,
    BUF_FULL
  } bufState_e;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// In-order buffer for deferred load results; push/pop in one cycle keeps the count.
// Pushes while full and pops while empty are ignored.
module wb_ld_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               pushDat,
  input  logic                       pop,
  output logic [W-1:0]               popDat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign popDat = mem[headPtr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + 1'b1;
      if (doPop)  headPtr <= headPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[tailPtr] <= pushDat;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB > buffered load > bypassed load, zero-cycle select.
// Load scoreboard drives hazard; ld_ready drops only when the buffer is full.
module regfile_wb_arbiter #(
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = regfile_wb_arbiter_pkg::DATA_W,
  parameter int REG_AW    = regfile_wb_arbiter_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_valid,
  input  logic [REG_AW-1:0]          wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       wb_llb,
  input  logic                       wb_lhb,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [REG_AW-1:0]          ld_reg,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       iss_valid,
  input  logic [REG_AW-1:0]          iss_reg,
  input  logic [REG_AW-1:0]          chk_reg1,
  input  logic [REG_AW-1:0]          chk_reg2,
  input  logic [REG_AW-1:0]          chk_dst,
  output logic                       hazard,
  output logic                       rf_WriteReg,
  output logic [REG_AW-1:0]          rf_DstReg,
  output logic [DATA_W-1:0]          rf_writedata,
  output logic                       rf_LLB,
  output logic                       rf_LHB,
  output logic [$clog2(BUF_DEPTH):0] buf_count
);
  import regfile_wb_arbiter_pkg::*;

  localparam int NREG = 2 ** REG_AW;
  localparam int EW   = REG_AW + DATA_W;

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pendNext;
  logic [EW-1:0]     headEnt;
  logic [REG_AW-1:0] headReg;
  logic [DATA_W-1:0] headData;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              ldAccept;
  logic              popHead;
  logic              bypass;
  logic              ldWrite;
  logic [REG_AW-1:0] ldWrReg;
  logic              selValid;
  bufState_e         bufState;

  assign {headReg, headData} = headEnt;

  always_comb begin
    bufState = BUF_PARTIAL;
    if (fifoEmpty)     bufState = BUF_EMPTY;
    else if (fifoFull) bufState = BUF_FULL;
  end

  assign ld_ready = (bufState != BUF_FULL);
  assign ldAccept = ld_valid && ld_ready;

  always_comb begin
    selValid     = 1'b0;
    rf_DstReg    = '0;
    rf_writedata = '0;
    rf_LLB       = 1'b0;
    rf_LHB       = 1'b0;
    popHead      = 1'b0;
    bypass       = 1'b0;
    ldWrite      = 1'b0;
    ldWrReg      = '0;
    if (wb_valid) begin
      selValid     = 1'b1;
      rf_DstReg    = wb_reg;
      rf_writedata = wb_data;
      rf_LLB       = wb_llb;
      rf_LHB       = wb_lhb;
    end else if (!fifoEmpty) begin
      selValid     = 1'b1;
      rf_DstReg    = headReg;
      rf_writedata = headData;
      popHead      = 1'b1;
      ldWrite      = 1'b1;
      ldWrReg      = headReg;
    end else if (ldAccept) begin
      selValid     = 1'b1;
      rf_DstReg    = ld_reg;
      rf_writedata = ld_data;
      bypass       = 1'b1;
      ldWrite      = 1'b1;
      ldWrReg      = ld_reg;
    end
  end

  // Reg 0 is hardwired: the port is claimed (pop/accept proceed) but nothing is written.
  assign rf_WriteReg = selValid && (rf_DstReg != REG_ZERO);

  wb_ld_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ldAccept && !bypass),
    .pushDat ({ld_reg, ld_data}),
    .pop     (popHead),
    .popDat  (headEnt),
    .count   (buf_count),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  // Set after clear so a same-cycle reissue of the retiring register stays pending.
  always_comb begin
    pendNext = pend;
    if (ldWrite) pendNext[ldWrReg] = 1'b0;
    if (iss_valid && (iss_reg != REG_ZERO)) pendNext[iss_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pendNext;
  end

  assign hazard = pend[chk_reg1] | pend[chk_reg2] | pend[chk_dst];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench comparing the arbiter against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        wb_valid, wb_llb, wb_lhb;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        ld_valid, ld_ready;
  logic [3:0]  ld_reg;
  logic [15:0] ld_data;
  logic        iss_valid;
  logic [3:0]  iss_reg, chk_reg1, chk_reg2, chk_dst;
  logic        hazard, rf_WriteReg, rf_LLB, rf_LHB;
  logic [3:0]  rf_DstReg;
  logic [15:0] rf_writedata;
  logic [1:0]  buf_count;

  regfile_wb_arbiter #(.BUF_DEPTH(DEPTH), .DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_llb(wb_llb), .wb_lhb(wb_lhb),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .chk_dst(chk_dst),
    .hazard(hazard), .rf_WriteReg(rf_WriteReg), .rf_DstReg(rf_DstReg),
    .rf_writedata(rf_writedata), .rf_LLB(rf_LLB), .rf_LHB(rf_LHB), .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t q[$];
  bit   pend[16];
  bit   lastAccepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    q.delete();
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
  endfunction

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle();
    bit         ready, accept, own, fromHead, fromLoad;
    logic [3:0] dst;
    logic [15:0] dat;
    bit         llb, lhb, expHaz;
    #1;
    ready  = (q.size() < DEPTH);
    accept = ld_valid && ready;
    own = 1'b0; fromHead = 1'b0; fromLoad = 1'b0;
    dst = '0; dat = '0; llb = 1'b0; lhb = 1'b0;
    if (wb_valid) begin
      own = 1'b1; dst = wb_reg; dat = wb_data; llb = wb_llb; lhb = wb_lhb;
    end else if (q.size() > 0) begin
      own = 1'b1; fromHead = 1'b1; dst = q[0].r; dat = q[0].d;
    end else if (accept) begin
      own = 1'b1; fromLoad = 1'b1; dst = ld_reg; dat = ld_data;
    end
    expHaz = pend[chk_reg1] || pend[chk_reg2] || pend[chk_dst];

    chk("ld_ready", 32'(ld_ready), 32'(ready));
    chk("buf_count", 32'(buf_count), 32'(q.size()));
    chk("hazard", 32'(hazard), 32'(expHaz));
    chk("rf_WriteReg", 32'(rf_WriteReg), 32'(own && dst != 4'd0));
    if (own && dst != 4'd0) begin
      chk("rf_DstReg", 32'(rf_DstReg), 32'(dst));
      chk("rf_writedata", 32'(rf_writedata), 32'(dat));
      chk("rf_LLB_LHB", 32'({rf_LLB, rf_LHB}), 32'({llb, lhb}));
    end

    @(posedge clk);
    if (fromHead) void'(q.pop_front());
    if (accept && !fromLoad) q.push_back('{r: ld_reg, d: ld_data});
    if (fromHead || fromLoad) pend[dst] = 1'b0;
    if (iss_valid && iss_reg != 4'd0) pend[iss_reg] = 1'b1;
    lastAccepted = accept;
    @(negedge clk);
  endtask

  task automatic idleInputs();
    wb_valid = 0; wb_reg = 0; wb_data = 0; wb_llb = 0; wb_lhb = 0;
    ld_valid = 0; ld_reg = 0; ld_data = 0;
    iss_valid = 0; iss_reg = 0; chk_reg1 = 0; chk_reg2 = 0; chk_dst = 0;
  endtask

  initial begin
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_buf_count", 32'(buf_count), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd1);
    chk("reset_hazard", 32'(hazard), 32'd0);
    chk("reset_rf_port", 32'({rf_WriteReg, rf_DstReg, rf_writedata, rf_LLB, rf_LHB}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Bypass
    ld_valid = 1; ld_reg = 4'd3; ld_data = 16'h1234;
    #1;
    chk("bypass_we", 32'(rf_WriteReg), 32'd1);
    chk("bypass_dst", 32'(rf_DstReg), 32'd3);
    chk("bypass_data", 32'(rf_writedata), 32'h1234);
    cycle();
    idleInputs();
    #1;
    chk("bypass_count", 32'(buf_count), 32'd0);
    cycle();

    // Contention
    wb_valid = 1; wb_reg = 4'd2; wb_data = 16'hC130;
    ld_valid = 1; ld_reg = 4'd4; ld_data = 16'h00A5;
    #1;
    chk("cont_wb_dst", 32'(rf_DstReg), 32'd2);
    cycle();
    ld_reg = 4'd5; ld_data = 16'h2570;
    cycle();
    ld_valid = 0;
    #1;
    chk("cont_count_full", 32'(buf_count), 32'd2);
    chk("cont_not_ready", 32'(ld_ready), 32'd0);
    chk("cont_wb_data", 32'(rf_writedata), 32'hC130);
    cycle();
    wb_valid = 0;
    #1;
    chk("cont_drain1", 32'({rf_WriteReg, rf_DstReg, rf_writedata}), {11'd0, 1'b1, 4'd4, 16'h00A5});
    cycle();
    #1;
    chk("cont_drain2", 32'({rf_WriteReg, rf_DstReg, rf_writedata}), {11'd0, 1'b1, 4'd5, 16'h2570});
    cycle();
    #1;
    chk("cont_empty", 32'(buf_count), 32'd0);

    // Scoreboard
    iss_valid = 1; iss_reg = 4'd7; chk_reg1 = 4'd7;
    cycle();
    iss_valid = 0;
    #1;
    chk("sb_hazard_set", 32'(hazard), 32'd1);
    cycle(); cycle();
    ld_valid = 1; ld_reg = 4'd7; ld_data = 16'hBEEF;
    #1;
    chk("sb_hazard_retire_cycle", 32'(hazard), 32'd1);
    cycle();
    ld_valid = 0;
    #1;
    chk("sb_hazard_cleared", 32'(hazard), 32'd0);
    iss_valid = 1;
    cycle();
    ld_valid = 1; ld_data = 16'h0707;
    cycle();
    ld_valid = 0; iss_valid = 0;
    #1;
    chk("sb_set_wins", 32'(hazard), 32'd1);
    ld_valid = 1;
    cycle();
    idleInputs();

    // Register 0
    ld_valid = 1; ld_reg = 4'd0; ld_data = 16'hFFFF; iss_valid = 1; iss_reg = 4'd0;
    #1;
    chk("r0_no_write", 32'(rf_WriteReg), 32'd0);
    cycle();
    idleInputs();
    #1;
    chk("r0_no_hazard", 32'(hazard), 32'd0);
    chk("r0_accepted", 32'(lastAccepted), 32'd1);
    wb_valid = 1; wb_reg = 4'd1; wb_data = 16'h0001; ld_valid = 1; ld_reg = 4'd0;
    cycle();
    idleInputs();
    #1;
    chk("r0_buffered", 32'(buf_count), 32'd1);
    chk("r0_drain_no_write", 32'(rf_WriteReg), 32'd0);
    cycle();

    // Reset mid-operation
    iss_valid = 1; iss_reg = 4'd5;
    cycle();
    iss_valid = 0; wb_valid = 1; wb_reg = 4'd9; wb_data = 16'h9999;
    ld_valid = 1; ld_reg = 4'd5; ld_data = 16'h5555;
    cycle(); cycle();
    idleInputs();
    chk_reg1 = 4'd5;
    #1;
    chk("mid_pre_count", 32'(buf_count), 32'd2);
    chk("mid_pre_hazard", 32'(hazard), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_count", 32'(buf_count), 32'd0);
    chk("mid_hazard", 32'(hazard), 32'd0);
    chk("mid_no_write", 32'(rf_WriteReg), 32'd0);
    rst_n = 1'b1;
    modelReset();
    @(negedge clk);
    cycle();

    // Random traffic; the load source holds its beat until accepted.
    for (int n = 0; n < 3000; n++) begin
      wb_valid = ($urandom_range(0, 9) < 4);
      wb_reg   = 4'($urandom);
      wb_data  = 16'($urandom);
      wb_llb   = 1'($urandom);
      wb_lhb   = 1'($urandom);
      if (!ld_valid || lastAccepted) begin
        ld_valid = ($urandom_range(0, 9) < 5);
        ld_reg   = 4'($urandom);
        ld_data  = 16'($urandom);
      end
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_reg   = 4'($urandom);
      chk_reg1  = 4'($urandom);
      chk_reg2  = 4'($urandom);
      chk_dst   = 4'($urandom);
      if (n % 700 == 699) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        modelReset();
        ld_valid = 1'b0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
